// File: rtl/tvm_mmap_copy_engine.sv
// Copies LEN words SRC->DST over the mmap read/write channels, issuing one pipelined read per cycle.
// First write strobe lands READ_LATENCY+2 cycles after the accepted start; neither channel can stall the engine.
module tvm_mmap_copy_engine #(
   parameter int DATA_WIDTH   = 8,
   parameter int ADDR_WIDTH   = 8,
   parameter int READ_LATENCY = 1
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic                  i_start,
   input  logic [ADDR_WIDTH-1:0] i_src_addr,
   input  logic [ADDR_WIDTH-1:0] i_dst_addr,
   input  logic [ADDR_WIDTH-1:0] i_len,
   output logic                  o_busy,
   output logic                  o_done,
   output logic [ADDR_WIDTH-1:0] o_count,
   output logic [ADDR_WIDTH-1:0] o_rd_addr,
   input  logic [DATA_WIDTH-1:0] i_rd_data,
   output logic [ADDR_WIDTH-1:0] o_wr_addr,
   output logic [DATA_WIDTH-1:0] o_wr_data,
   output logic                  o_wr_en
);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

   state_t                r_state;
   logic [ADDR_WIDTH-1:0] r_src;
   logic [ADDR_WIDTH-1:0] r_dst;
   logic [ADDR_WIDTH-1:0] r_len;
   logic [ADDR_WIDTH-1:0] r_issued;
   logic [ADDR_WIDTH-1:0] r_count;
   logic [ADDR_WIDTH-1:0] r_rd_addr;
   logic [ADDR_WIDTH-1:0] r_wr_addr;
   logic [DATA_WIDTH-1:0] r_wr_data;
   logic                  r_busy;
   logic                  r_done;
   logic                  r_wr_en;
   logic [READ_LATENCY:0] r_pipe;

   logic                  w_accept;
   logic                  w_issue;
   logic [ADDR_WIDTH-1:0] w_issued_nxt;

   assign w_accept     = (r_state == S_IDLE) && i_start;
   assign w_issue      = (w_accept && (i_len != '0)) || (r_state == S_RUN);
   assign w_issued_nxt = r_issued + 1'b1;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state   <= S_IDLE;
         r_src     <= '0;
         r_dst     <= '0;
         r_len     <= '0;
         r_issued  <= '0;
         r_count   <= '0;
         r_rd_addr <= '0;
         r_wr_addr <= '0;
         r_wr_data <= '0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_wr_en   <= 1'b0;
         r_pipe    <= '0;
      end else begin
         // A token leaving the pipe marks the cycle its read data is on i_rd_data.
         r_pipe  <= {r_pipe[READ_LATENCY-1:0], w_issue};
         r_wr_en <= r_pipe[READ_LATENCY];
         r_done  <= 1'b0;
         if (r_pipe[READ_LATENCY]) begin
            r_wr_addr <= r_dst + r_count;
            r_wr_data <= i_rd_data;
            r_count   <= r_count + 1'b1;
         end

         case (r_state)
            S_IDLE: begin
               if (i_start) begin
                  r_src   <= i_src_addr;
                  r_dst   <= i_dst_addr;
                  r_len   <= i_len;
                  r_count <= '0;
                  if (i_len == '0) begin
                     r_state <= S_DONE;
                     r_done  <= 1'b1;
                  end else begin
                     r_rd_addr <= i_src_addr;
                     r_issued  <= {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
                     r_busy    <= 1'b1;
                     r_state   <= (i_len == {{(ADDR_WIDTH-1){1'b0}}, 1'b1}) ? S_DRAIN : S_RUN;
                  end
               end
            end
            S_RUN: begin
               r_rd_addr <= r_src + r_issued;
               r_issued  <= w_issued_nxt;
               if (w_issued_nxt == r_len) begin
                  r_state <= S_DRAIN;
               end
            end
            S_DRAIN: begin
               if ((r_count == r_len) && (r_pipe == '0)) begin
                  r_state <= S_DONE;
                  r_done  <= 1'b1;
                  r_busy  <= 1'b0;
               end
            end
            S_DONE: begin
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign o_busy    = r_busy;
   assign o_done    = r_done;
   assign o_count   = r_count;
   assign o_rd_addr = r_rd_addr;
   assign o_wr_addr = r_wr_addr;
   assign o_wr_data = r_wr_data;
   assign o_wr_en   = r_wr_en;

endmodule

// File: tb/tb_tvm_mmap_copy_engine.sv
// Self-checking bench: two engines (read latency 1 and 3) against behavioural memories and a sequential copy model.
module tb_tvm_mmap_copy_engine;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start;
   logic       sel;
   logic [7:0] src, dst, len;

   logic       start1, start3;
   logic       busy1, done1, wr_en1, busy3, done3, wr_en3;
   logic [7:0] count1, rd_addr1, rd_data1, wr_addr1, wr_data1;
   logic [7:0] count3, rd_addr3, rd_data3, wr_addr3, wr_data3;

   logic       v_busy, v_done, v_wr_en;
   logic [7:0] v_count, v_rd_addr, v_wr_addr, v_wr_data;

   logic [7:0]  mem [2][256];
   logic [7:0]  ref_mem [256];
   logic [7:0]  rp1;
   logic [23:0] rp3;

   int n_chk = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   assign start1 = start & ~sel;
   assign start3 = start & sel;

   tvm_mmap_copy_engine #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .READ_LATENCY(1)) u_dut1 (
      .i_clk(clk), .i_rst_n(rst_n), .i_start(start1),
      .i_src_addr(src), .i_dst_addr(dst), .i_len(len),
      .o_busy(busy1), .o_done(done1), .o_count(count1),
      .o_rd_addr(rd_addr1), .i_rd_data(rd_data1),
      .o_wr_addr(wr_addr1), .o_wr_data(wr_data1), .o_wr_en(wr_en1)
   );

   tvm_mmap_copy_engine #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .READ_LATENCY(3)) u_dut3 (
      .i_clk(clk), .i_rst_n(rst_n), .i_start(start3),
      .i_src_addr(src), .i_dst_addr(dst), .i_len(len),
      .o_busy(busy3), .o_done(done3), .o_count(count3),
      .o_rd_addr(rd_addr3), .i_rd_data(rd_data3),
      .o_wr_addr(wr_addr3), .o_wr_data(wr_data3), .o_wr_en(wr_en3)
   );

   // Read responders: data appears 1 (resp. 3) cycles after the address.
   always @(posedge clk) begin
      rp1 <= mem[0][rd_addr1];
      rp3 <= {rp3[15:0], mem[1][rd_addr3]};
   end
   assign rd_data1 = rp1;
   assign rd_data3 = rp3[23:16];

   assign v_busy    = sel ? busy3    : busy1;
   assign v_done    = sel ? done3    : done1;
   assign v_wr_en   = sel ? wr_en3   : wr_en1;
   assign v_count   = sel ? count3   : count1;
   assign v_rd_addr = sel ? rd_addr3 : rd_addr1;
   assign v_wr_addr = sel ? wr_addr3 : wr_addr1;
   assign v_wr_data = sel ? wr_data3 : wr_data1;

   task automatic check(input string nm, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endtask

   // One transfer; the write side of the responder is emulated here so the bench owns the memory.
   task automatic run(input string nm, input logic s, input logic [7:0] a_src, a_dst, a_len,
                      input int xcyc, input logic [7:0] x_src, x_len,
                      input int exp_first, exp_done, input bit chk_data);
      int first = -1, last = -1, nwr = 0, gap = 0, done_cyc = -1, ndone = 0;
      int busy_err = 0, ra_err = 0, wa_err = 0, wd_err = 0, m_err = 0;
      logic [7:0] exp_data [256];
      bit exp_busy;
      sel = s;
      for (int i = 0; i < 256; i++) mem[s][i] = ref_mem[i];
      for (int i = 0; i < int'(a_len); i++) begin
         exp_data[i] = ref_mem[8'(a_src + i)];
         ref_mem[8'(a_dst + i)] = exp_data[i];
      end
      @(negedge clk);
      src = a_src; dst = a_dst; len = a_len; start = 1'b1;
      for (int cyc = 1; cyc <= exp_done + 3; cyc++) begin
         @(negedge clk);
         exp_busy = (a_len != 8'd0) && (cyc < exp_done);
         if (v_busy !== exp_busy) busy_err++;
         if (cyc <= int'(a_len) && v_rd_addr !== 8'(a_src + cyc - 1)) ra_err++;
         if (v_wr_en === 1'b1) begin
            if (first < 0) first = cyc;
            else if (cyc != last + 1) gap++;
            last = cyc;
            if (v_wr_addr !== 8'(a_dst + nwr)) wa_err++;
            if (chk_data && nwr < int'(a_len) && v_wr_data !== exp_data[nwr]) wd_err++;
            mem[s][v_wr_addr] = v_wr_data;
            nwr++;
         end
         if (v_done === 1'b1) begin
            ndone++;
            done_cyc = cyc;
         end
         start = (cyc == xcyc);
         if (cyc == xcyc) begin
            src = x_src; len = x_len; dst = x_src + 8'h33;
         end
      end
      if (chk_data) begin
         for (int i = 0; i < 256; i++) if (mem[s][i] !== ref_mem[i]) m_err++;
         check({nm, " data_errs"}, wd_err, 0);
         check({nm, " mem_errs"}, m_err, 0);
      end
      check({nm, " first_wr_cycle"}, first, exp_first);
      check({nm, " n_writes"}, nwr, int'(a_len));
      check({nm, " write_gaps"}, gap, 0);
      check({nm, " done_cycle"}, done_cyc, exp_done);
      check({nm, " done_pulses"}, ndone, 1);
      check({nm, " count"}, int'(v_count), int'(a_len));
      check({nm, " busy_errs"}, busy_err, 0);
      check({nm, " rd_addr_errs"}, ra_err, 0);
      check({nm, " wr_addr_errs"}, wa_err, 0);
   endtask

   typedef struct {
      logic       sel;
      logic [7:0] src, dst, len;
      int         xcyc;
      logic [7:0] xsrc, xlen;
      int         first, done_c;
      bit         chk;
   } vec_t;

   vec_t vt [9];

   initial begin
      logic [7:0] basic_pat [4];
      int nwr, ok;
      basic_pat[0] = 8'hA1; basic_pat[1] = 8'hB2; basic_pat[2] = 8'hC3; basic_pat[3] = 8'hD4;

      //        sel   src    dst    len    xcyc xsrc  xlen   first done chk
      vt[0] = '{1'b0, 8'h10, 8'h40, 8'd4,   0, 8'h00, 8'd0,  3,    7, 1'b1};
      vt[1] = '{1'b0, 8'h33, 8'h50, 8'd0,   0, 8'h00, 8'd0, -1,    1, 1'b1};
      vt[2] = '{1'b0, 8'hFE, 8'hFF, 8'd3,   0, 8'h00, 8'd0,  3,    6, 1'b0};
      vt[3] = '{1'b0, 8'hFD, 8'h02, 8'd5,   0, 8'h00, 8'd0,  3,    8, 1'b1};
      vt[4] = '{1'b1, 8'h20, 8'h60, 8'd5,   0, 8'h00, 8'd0,  5,   10, 1'b1};
      vt[5] = '{1'b0, 8'h30, 8'h90, 8'd6,   3, 8'h00, 8'd5,  3,    9, 1'b1};
      vt[6] = '{1'b0, 8'h70, 8'hA0, 8'd2,   5, 8'h11, 8'd7,  3,    5, 1'b1};
      vt[7] = '{1'b1, 8'h05, 8'h09, 8'd1,   0, 8'h00, 8'd0,  5,    6, 1'b1};
      vt[8] = '{1'b0, 8'h00, 8'h80, 8'd255, 0, 8'h00, 8'd0,  3,  258, 1'b1};

      for (int i = 0; i < 256; i++) ref_mem[i] = 8'($urandom);
      for (int i = 0; i < 4; i++) ref_mem[8'h10 + i] = basic_pat[i];
      for (int i = 0; i < 256; i++) begin
         mem[0][i] = ref_mem[i];
         mem[1][i] = ref_mem[i];
      end

      rst_n = 1'b0; start = 1'b0; sel = 1'b0; src = '0; dst = '0; len = '0;
      repeat (3) @(negedge clk);
      check("reset busy", int'(busy1), 0);
      check("reset done", int'(done1), 0);
      check("reset wr_en", int'(wr_en1), 0);
      check("reset count", int'(count1), 0);
      check("reset rd_addr", int'(rd_addr1), 0);
      check("reset wr_addr", int'(wr_addr1), 0);
      check("reset wr_data", int'(wr_data1), 0);
      rst_n = 1'b1;

      foreach (vt[i]) begin
         run($sformatf("vec%0d", i), vt[i].sel, vt[i].src, vt[i].dst, vt[i].len, vt[i].xcyc,
             vt[i].xsrc, vt[i].xlen, vt[i].first, vt[i].done_c, vt[i].chk);
         if (i == 0)
            for (int k = 0; k < 4; k++)
               check($sformatf("basic mem[%0h]", 8'h40 + k), int'(mem[0][8'h40 + k]), int'(basic_pat[k]));
      end

      // Mid-transfer reset after the third write.
      sel = 1'b0;
      for (int i = 0; i < 256; i++) mem[0][i] = ref_mem[i];
      @(negedge clk);
      src = 8'h20; dst = 8'hC0; len = 8'd8; start = 1'b1;
      nwr = 0;
      ok = 0;
      for (int cyc = 1; cyc <= 20 && ok == 0; cyc++) begin
         @(negedge clk);
         start = 1'b0;
         if (wr_en1 === 1'b1) nwr++;
         if (nwr == 3) ok = 1;
      end
      check("rst reached 3 writes", ok, 1);
      rst_n = 1'b0;
      #1;
      check("rst wr_en drop", int'(wr_en1), 0);
      check("rst busy drop", int'(busy1), 0);
      check("rst done low", int'(done1), 0);
      check("rst count clear", int'(count1), 0);
      @(negedge clk);
      rst_n = 1'b1;
      nwr = 0;
      for (int cyc = 0; cyc < 20; cyc++) begin
         @(negedge clk);
         if (wr_en1 === 1'b1 || busy1 === 1'b1 || done1 === 1'b1) nwr++;
      end
      check("rst no activity after release", nwr, 0);

      // Randomised transfers; destination kept outside the read-ahead overlap window.
      for (int r = 0; r < 16; r++) begin
         logic       s;
         logic [7:0] a_src, a_len, d;
         int         lat, ef, ed, xc;
         s     = 1'($urandom_range(0, 1));
         lat   = s ? 3 : 1;
         a_src = 8'($urandom);
         a_len = 8'($urandom_range(0, 24));
         do d = 8'($urandom); while (int'(d) >= 1 && int'(d) <= lat + 1);
         ef = (a_len == 0) ? -1 : 2 + lat;
         ed = (a_len == 0) ? 1 : int'(a_len) + 2 + lat;
         xc = $urandom_range(0, ed);
         run($sformatf("rand%0d", r), s, a_src, 8'(a_src + d), a_len, xc,
             8'($urandom), 8'($urandom), ef, ed, 1'b1);
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
